conf_fb_detect: RTL and testbench

- Feedback-conditioning stage directly upstream of the CONF_<N>BITS configuration block.
- Samples the two raw asynchronous inverter-chain sense outputs (up-chain, down-chain) and synchronizes them.
- Majority-votes each channel over a fixed window and drives registered, glitch-free, mutually exclusive O_INVU/O_INVD steering levels into CONF.
- Reports lock once the chains stay balanced for several consecutive windows.

---
 rtl/conf_pkg.sv | 20 ++
 rtl/conf_sync2.sv | 25 ++
 rtl/conf_fb_detect.sv | 167 ++++++++++++++++
 tb/tb_conf_fb_detect.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/conf_pkg.sv
// Shared types for the CONF feedback detector:
// FSM states, steer result codes, counter width helper.
package conf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam logic [1:0] STEER_UP = 2'b10;
  localparam logic [1:0] STEER_DN = 2'b01;
  localparam logic [1:0] BAL      = 2'b00;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conf_sync2.sv
// Two-flop synchronizer with synchronous active-high reset.
// Ports: clk, rst, d (async in), q (synchronized out).
module conf_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/conf_fb_detect.sv
// Feedback conditioning ahead of CONF: sync, windowed vote, steer, lock.
// Ports: CLK, RST, EN, RAW_INVU/D in; O_INVU/D, WIN_DONE, CONFLICT, LOCK out.
module conf_fb_detect
  import conf_pkg::*;
#(
  parameter int WIN_CYCLES   = 16,
  parameter int THRESH       = 9,
  parameter int LOCK_WINDOWS = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic RAW_INVU,
  input  logic RAW_INVD,
  output logic O_INVU,
  output logic O_INVD,
  output logic WIN_DONE,
  output logic CONFLICT,
  output logic LOCK
);

  localparam int SW = cnt_w(WIN_CYCLES + 1);
  localparam int WW = cnt_w(WIN_CYCLES);
  localparam int BW = cnt_w(LOCK_WINDOWS + 1);

  localparam logic [WW-1:0] WLAST = WW'(WIN_CYCLES - 1);
  localparam logic [SW-1:0] THR   = SW'(THRESH);
  localparam logic [BW-1:0] BMAX  = BW'(LOCK_WINDOWS);

  logic s_u;
  logic s_d;

  conf_sync2 u_sync_u (
    .clk (CLK),
    .rst (RST),
    .d   (RAW_INVU),
    .q   (s_u)
  );

  conf_sync2 u_sync_d (
    .clk (CLK),
    .rst (RST),
    .d   (RAW_INVD),
    .q   (s_d)
  );

  state_e          state_q, state_d;
  logic [SW-1:0]   cnt_u_q, cnt_u_d;
  logic [SW-1:0]   cnt_d_q, cnt_d_d;
  logic [WW-1:0]   win_q, win_d;
  logic [BW-1:0]   bal_q, bal_d;
  logic [1:0]      o_q, o_d;
  logic            done_q, done_d;
  logic            conf_q, conf_d;
  logic            lock_q, lock_d;

  logic [SW-1:0]   sum_u;
  logic [SW-1:0]   sum_d;
  logic            v_u;
  logic            v_d;

  always_comb begin
    state_d = state_q;
    cnt_u_d = cnt_u_q;
    cnt_d_d = cnt_d_q;
    win_d   = win_q;
    bal_d   = bal_q;
    o_d     = o_q;
    done_d  = 1'b0;
    conf_d  = 1'b0;
    sum_u   = cnt_u_q + {{(SW-1){1'b0}}, s_u};
    sum_d   = cnt_d_q + {{(SW-1){1'b0}}, s_d};
    v_u     = (sum_u >= THR);
    v_d     = (sum_d >= THR);

    unique case (state_q)
      IDLE: begin
        cnt_u_d = '0;
        cnt_d_d = '0;
        win_d   = '0;
        bal_d   = '0;
        o_d     = BAL;
        if (EN) state_d = ACQUIRE;
      end
      ACQUIRE, LOCKED: begin
        if (!EN) begin
          // Disable wins over a window that ends on the same edge.
          state_d = IDLE;
          cnt_u_d = '0;
          cnt_d_d = '0;
          win_d   = '0;
          bal_d   = '0;
          o_d     = BAL;
        end else if (win_q == WLAST) begin
          cnt_u_d = '0;
          cnt_d_d = '0;
          win_d   = '0;
          done_d  = 1'b1;
          unique case ({v_u, v_d})
            STEER_UP: begin
              o_d     = STEER_UP;
              bal_d   = '0;
              state_d = ACQUIRE;
            end
            STEER_DN: begin
              o_d     = STEER_DN;
              bal_d   = '0;
              state_d = ACQUIRE;
            end
            BAL: begin
              o_d   = BAL;
              bal_d = (bal_q == BMAX) ? BMAX : bal_q + BW'(1);
              if (bal_d == BMAX) state_d = LOCKED;
            end
            default: begin
              // Both high: keep the previous steer, it is still safe.
              conf_d  = 1'b1;
              bal_d   = '0;
              state_d = ACQUIRE;
            end
          endcase
        end else begin
          cnt_u_d = sum_u;
          cnt_d_d = sum_d;
          win_d   = win_q + WW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        o_d     = BAL;
      end
    endcase

    lock_d = (state_d == LOCKED);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_u_q <= '0;
      cnt_d_q <= '0;
      win_q   <= '0;
      bal_q   <= '0;
      o_q     <= BAL;
      done_q  <= 1'b0;
      conf_q  <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_u_q <= cnt_u_d;
      cnt_d_q <= cnt_d_d;
      win_q   <= win_d;
      bal_q   <= bal_d;
      o_q     <= o_d;
      done_q  <= done_d;
      conf_q  <= conf_d;
      lock_q  <= lock_d;
    end
  end

  assign O_INVU   = o_q[1];
  assign O_INVD   = o_q[0];
  assign WIN_DONE = done_q;
  assign CONFLICT = conf_q;
  assign LOCK     = lock_q;

endmodule

// File: tb/tb_conf_fb_detect.sv
// Directed bench for conf_fb_detect: window vote table
// plus reset, idle and mid-window abort sequences.
module tb_conf_fb_detect;

  logic CLK = 1'b0;
  logic RST;
  logic EN;
  logic RAW_INVU;
  logic RAW_INVD;
  logic O_INVU;
  logic O_INVD;
  logic WIN_DONE;
  logic CONFLICT;
  logic LOCK;

  conf_fb_detect dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .RAW_INVU (RAW_INVU),
    .RAW_INVD (RAW_INVD),
    .O_INVU   (O_INVU),
    .O_INVD   (O_INVD),
    .WIN_DONE (WIN_DONE),
    .CONFLICT (CONFLICT),
    .LOCK     (LOCK)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         nu;
    int         nd;
    logic [1:0] o;
    logic       c;
    logic       l;
  } vec_t;

  vec_t tbl [18];
  int   tests = 0;
  int   fails = 0;
  int   inv_bad = 0;

  always @(negedge CLK)
    if (O_INVU & O_INVD) inv_bad++;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {WIN_DONE, O_INVU, O_INVD, CONFLICT, LOCK};
  endfunction

  // Synchronized sample k of a run starting at table row first.
  function automatic logic smp(input int first, input int n,
                               input int k, input bit up);
    int w;
    int j;
    if (k >= n) return 1'b0;
    w = first + k / 16;
    j = k % 16;
    return up ? (j < tbl[w].nu) : (j < tbl[w].nd);
  endfunction

  // Enter from IDLE at a negedge with EN=0. RAW leads the
  // counted sample by two edges through the synchronizer.
  task automatic run_vecs(input int first, input int last);
    int n;
    int spur;
    int w;
    n = (last - first + 1) * 16;
    spur = 0;
    RAW_INVU = smp(first, n, 0, 1'b1);
    RAW_INVD = smp(first, n, 0, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    EN = 1'b1;
    RAW_INVU = smp(first, n, 1, 1'b1);
    RAW_INVD = smp(first, n, 1, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    if (WIN_DONE) spur++;
    for (int k = 1; k <= n; k++) begin
      RAW_INVU = smp(first, n, k + 1, 1'b1);
      RAW_INVD = smp(first, n, k + 1, 1'b0);
      @(posedge CLK);
      @(negedge CLK);
      if (k % 16 == 0) begin
        w = first + k / 16 - 1;
        chk($sformatf("win%0d", w), 32'(outs()),
            32'({1'b1, tbl[w].o, tbl[w].c, tbl[w].l}));
      end else if (WIN_DONE) begin
        spur++;
      end
    end
    chk($sformatf("spurious_done_%0d", first), spur, 0);
  endtask

  initial begin
    int bad;
    tbl[0]  = '{16,  0, 2'b10, 1'b0, 1'b0};
    tbl[1]  = '{ 9,  0, 2'b10, 1'b0, 1'b0};
    tbl[2]  = '{ 8,  0, 2'b00, 1'b0, 1'b0};
    tbl[3]  = '{ 0, 16, 2'b01, 1'b0, 1'b0};
    tbl[4]  = '{16, 16, 2'b01, 1'b1, 1'b0};
    tbl[5]  = '{ 0,  0, 2'b00, 1'b0, 1'b0};
    tbl[6]  = '{ 0,  0, 2'b00, 1'b0, 1'b0};
    tbl[7]  = '{ 0,  0, 2'b00, 1'b0, 1'b0};
    tbl[8]  = '{ 0,  0, 2'b00, 1'b0, 1'b1};
    tbl[9]  = '{ 0,  9, 2'b01, 1'b0, 1'b0};
    tbl[10] = '{ 9,  9, 2'b01, 1'b1, 1'b0};
    tbl[11] = '{ 3,  8, 2'b00, 1'b0, 1'b0};
    tbl[12] = '{ 8,  9, 2'b01, 1'b0, 1'b0};
    tbl[13] = '{ 0,  0, 2'b00, 1'b0, 1'b0};
    tbl[14] = '{ 0,  0, 2'b00, 1'b0, 1'b0};
    tbl[15] = '{ 0,  0, 2'b00, 1'b0, 1'b0};
    tbl[16] = '{ 0,  0, 2'b00, 1'b0, 1'b1};
    tbl[17] = '{ 8,  0, 2'b00, 1'b0, 1'b0};

    RST = 1'b1;
    EN = 1'b0;
    RAW_INVU = 1'b0;
    RAW_INVD = 1'b1;
    repeat (3) begin
      @(posedge CLK);
      @(negedge CLK);
      RAW_INVU = ~RAW_INVU;
      RAW_INVD = ~RAW_INVD;
    end
    chk("reset_state", 32'(outs()), 0);
    RST = 1'b0;

    bad = 0;
    repeat (40) begin
      RAW_INVU = ~RAW_INVU;
      RAW_INVD = 1'($urandom);
      @(posedge CLK);
      @(negedge CLK);
      if (outs() != 5'b0) bad++;
    end
    chk("idle_quiet", bad, 0);

    run_vecs(0, 16);

    // Abort by EN=0 with the window counter at 7 while LOCKED.
    RAW_INVU = 1'b1;
    RAW_INVD = 1'b0;
    bad = 0;
    repeat (7) begin
      @(posedge CLK);
      @(negedge CLK);
      if (WIN_DONE) bad++;
    end
    chk("locked_partial_no_done", bad, 0);
    chk("locked_before_abort", 32'(LOCK), 1);
    EN = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("abort_en", 32'(outs()), 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    run_vecs(17, 17);

    EN = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    run_vecs(13, 16);

    // Same abort, this time through RST with EN still high.
    RAW_INVU = 1'b1;
    repeat (7) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("abort_rst", 32'(outs()), 0);
    RST = 1'b0;
    EN = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    run_vecs(17, 17);

    chk("steer_mutex", inv_bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
